// File: rtl/rv32i_types.sv
// Shared RV32I types: load result broadcast, memory-controller FSM states and
// load/store funct3 encodings, plus store lane helpers.
package rv32i_types;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_ID_W = 5;
  localparam int unsigned MBE_W    = XLEN / 8;

  typedef struct packed {
    logic [REG_ID_W-1:0] reg_id;
    logic [XLEN-1:0]     data;
  } command_buffer;

  typedef enum logic [1:0] {
    MC_IDLE    = 2'd0,
    MC_LD_REQ  = 2'd1,
    MC_LD_DONE = 2'd2,
    MC_ST_REQ  = 2'd3
  } mem_ctrl_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Halfword lanes use only off[1]; words ignore the offset entirely.
  function automatic logic [MBE_W-1:0] store_mbe(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return MBE_W'(4'b0001 << off);
      F3_SH:   return MBE_W'(4'b0011 << {off[1], 1'b0});
      default: return MBE_W'(4'b1111);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] data);
    case (f3)
      F3_SB:   return XLEN'(data << {off, 3'b000});
      F3_SH:   return XLEN'(data << {off[1], 4'b0000});
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends the addressed byte or halfword of a read word.
module load_align
  import rv32i_types::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data_c = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data_c = {24'd0, byte_v};
      F3_LH:   data_c = {{16{half_v[15]}}, half_v};
      F3_LHU:  data_c = {16'd0, half_v};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/ld_st_mem_ctrl.sv
// Arbitrates the load and store queue heads onto the single data-memory port,
// one transaction at a time, and broadcasts aligned load results.
module ld_st_mem_ctrl
  import rv32i_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_head_ready,
  input  logic [REG_ID_W-1:0] ld_head_id,
  input  logic [2:0]          ld_head_funct3,
  input  logic [XLEN-1:0]     ld_head_address,
  output logic                ld_del_head,
  input  logic                st_head_ready,
  input  logic [2:0]          st_head_funct3,
  input  logic [XLEN-1:0]     st_head_address,
  input  logic [XLEN-1:0]     st_head_data,
  output logic                st_del_head,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [XLEN-1:0]     dmem_address,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [MBE_W-1:0]    dmem_mbe,
  input  logic [XLEN-1:0]     dmem_rdata,
  input  logic                dmem_resp,
  output command_buffer       cmd_buf_ld,
  output logic                busy
);

  localparam logic GRANT_LD = 1'b0;
  localparam logic GRANT_ST = 1'b1;

  mem_ctrl_state_t     state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [REG_ID_W-1:0] ld_id_q, ld_id_d;
  logic [2:0]          ld_f3_q, ld_f3_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic                dmem_read_q, dmem_read_d;
  logic                dmem_write_q, dmem_write_d;
  logic [XLEN-1:0]     dmem_address_q, dmem_address_d;
  logic [XLEN-1:0]     dmem_wdata_q, dmem_wdata_d;
  logic [MBE_W-1:0]    dmem_mbe_q, dmem_mbe_d;
  command_buffer       cmd_buf_q, cmd_buf_d;
  logic                ld_del_head_q, ld_del_head_d;
  logic                busy_q, busy_d;
  logic                grant_ld, grant_st;
  logic [XLEN-1:0]     ld_aligned_c;

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .funct3 (ld_f3_q),
    .off    (ld_off_q),
    .data_c (ld_aligned_c)
  );

  // Ties go to the side that did not win last time.
  always_comb begin
    grant_ld = ld_head_ready && (!st_head_ready || (last_grant_q == GRANT_ST));
    grant_st = st_head_ready && !grant_ld;
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    ld_id_d        = ld_id_q;
    ld_f3_d        = ld_f3_q;
    ld_off_d       = ld_off_q;
    dmem_read_d    = dmem_read_q;
    dmem_write_d   = dmem_write_q;
    dmem_address_d = dmem_address_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_mbe_d     = dmem_mbe_q;
    cmd_buf_d      = '0;
    ld_del_head_d  = 1'b0;

    case (state_q)
      MC_IDLE: begin
        if (grant_ld) begin
          state_d        = MC_LD_REQ;
          last_grant_d   = GRANT_LD;
          ld_id_d        = ld_head_id;
          ld_f3_d        = ld_head_funct3;
          ld_off_d       = ld_head_address[1:0];
          dmem_read_d    = 1'b1;
          dmem_address_d = {ld_head_address[XLEN-1:2], 2'b00};
          dmem_mbe_d     = '0;
          dmem_wdata_d   = '0;
        end else if (grant_st) begin
          state_d        = MC_ST_REQ;
          last_grant_d   = GRANT_ST;
          dmem_write_d   = 1'b1;
          dmem_address_d = {st_head_address[XLEN-1:2], 2'b00};
          dmem_mbe_d     = store_mbe(st_head_funct3, st_head_address[1:0]);
          dmem_wdata_d   = store_wdata(st_head_funct3, st_head_address[1:0], st_head_data);
        end
      end
      MC_LD_REQ: begin
        if (dmem_resp) begin
          state_d          = MC_LD_DONE;
          dmem_read_d      = 1'b0;
          ld_del_head_d    = 1'b1;
          cmd_buf_d.reg_id = ld_id_q;
          cmd_buf_d.data   = ld_aligned_c;
        end
      end
      MC_LD_DONE: state_d = MC_IDLE;
      MC_ST_REQ: begin
        if (dmem_resp) begin
          state_d      = MC_IDLE;
          dmem_write_d = 1'b0;
        end
      end
      default: state_d = MC_IDLE;
    endcase

    busy_d = (state_d != MC_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= MC_IDLE;
      last_grant_q   <= GRANT_LD;
      ld_id_q        <= '0;
      ld_f3_q        <= '0;
      ld_off_q       <= '0;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_address_q <= '0;
      dmem_wdata_q   <= '0;
      dmem_mbe_q     <= '0;
      cmd_buf_q      <= '0;
      ld_del_head_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      ld_id_q        <= ld_id_d;
      ld_f3_q        <= ld_f3_d;
      ld_off_q       <= ld_off_d;
      dmem_read_q    <= dmem_read_d;
      dmem_write_q   <= dmem_write_d;
      dmem_address_q <= dmem_address_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_mbe_q     <= dmem_mbe_d;
      cmd_buf_q      <= cmd_buf_d;
      ld_del_head_q  <= ld_del_head_d;
      busy_q         <= busy_d;
    end
  end

  // Store pop coincides with the completing response, so it cannot be registered.
  assign st_del_head  = (state_q == MC_ST_REQ) && dmem_resp;
  assign ld_del_head  = ld_del_head_q;
  assign dmem_read    = dmem_read_q;
  assign dmem_write   = dmem_write_q;
  assign dmem_address = dmem_address_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_mbe     = dmem_mbe_q;
  assign cmd_buf_ld   = cmd_buf_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ld_st_mem_ctrl.sv
// Directed plus randomized bench for ld_st_mem_ctrl with a behavioural memory
// responder and reference model for arbitration, alignment and byte lanes.
module tb_ld_st_mem_ctrl;
  import rv32i_types::*;

  logic          clk;
  logic          rst;
  logic          ld_head_ready;
  logic [4:0]    ld_head_id;
  logic [2:0]    ld_head_funct3;
  logic [31:0]   ld_head_address;
  logic          ld_del_head;
  logic          st_head_ready;
  logic [2:0]    st_head_funct3;
  logic [31:0]   st_head_address;
  logic [31:0]   st_head_data;
  logic          st_del_head;
  logic          dmem_read;
  logic          dmem_write;
  logic [31:0]   dmem_address;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_mbe;
  logic [31:0]   dmem_rdata;
  logic          dmem_resp;
  command_buffer cmd_buf_ld;
  logic          busy;

  ld_st_mem_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ld_head_ready   (ld_head_ready),
    .ld_head_id      (ld_head_id),
    .ld_head_funct3  (ld_head_funct3),
    .ld_head_address (ld_head_address),
    .ld_del_head     (ld_del_head),
    .st_head_ready   (st_head_ready),
    .st_head_funct3  (st_head_funct3),
    .st_head_address (st_head_address),
    .st_head_data    (st_head_data),
    .st_del_head     (st_del_head),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .dmem_address    (dmem_address),
    .dmem_wdata      (dmem_wdata),
    .dmem_mbe        (dmem_mbe),
    .dmem_rdata      (dmem_rdata),
    .dmem_resp       (dmem_resp),
    .cmd_buf_ld      (cmd_buf_ld),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit last_st = 1'b0;  // model: 1 when the store side won the previous grant

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned off;
    logic [31:0] b, h;
    off = 32'(addr[1:0]);
    b = (rd >> (8 * off)) & 32'h0000_00FF;
    h = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_mbe(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off;
    off = 32'(addr[1:0]);
    case (f3)
      3'b000:  return 4'(1 << off);
      3'b001:  return 4'(3 << (2 * (off / 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] d);
    int unsigned off;
    off = 32'(addr[1:0]);
    case (f3)
      3'b000:  return d << (8 * off);
      3'b001:  return d << (16 * (off / 2));
      default: return d;
    endcase
  endfunction

  // One transaction: predicts the winner, waits for the request, answers after
  // 'waits' stall cycles, and checks pops/broadcast. Ends with the served head popped.
  task automatic run_txn(input int waits, input logic [31:0] rdata, input bit scramble,
                         output bit got_ld);
    bit          exp_ld, seen;
    logic [4:0]  m_id;
    logic [2:0]  m_ldf3, m_stf3;
    logic [31:0] m_ldaddr, m_staddr, m_stdata, m_addr;
    exp_ld   = (ld_head_ready && st_head_ready) ? last_st : ld_head_ready;
    last_st  = !exp_ld;
    m_id     = ld_head_id;
    m_ldf3   = ld_head_funct3;
    m_ldaddr = ld_head_address;
    m_stf3   = st_head_funct3;
    m_staddr = st_head_address;
    m_stdata = st_head_data;
    m_addr   = exp_ld ? {m_ldaddr[31:2], 2'b00} : {m_staddr[31:2], 2'b00};
    seen     = 1'b0;
    got_ld   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = dmem_read || dmem_write;
    end
    chk("req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    got_ld = dmem_read;
    chk("grant_read", 32'(dmem_read), 32'(exp_ld));
    chk("grant_write", 32'(dmem_write), 32'(!exp_ld));
    if (scramble) begin
      if (exp_ld) begin
        ld_head_address = $urandom;
        ld_head_funct3  = 3'($urandom);
        ld_head_id      = 5'($urandom_range(1, 31));
      end else begin
        st_head_address = $urandom;
        st_head_data    = $urandom;
        st_head_funct3  = 3'($urandom_range(0, 2));
      end
    end
    for (int w = 0; w <= waits; w++) begin
      if (w > 0) @(negedge clk);
      chk("addr", dmem_address, m_addr);
      chk("rw_excl", 32'(dmem_read && dmem_write), 32'd0);
      chk("req_held", 32'(exp_ld ? dmem_read : dmem_write), 32'd1);
      chk("ld_pop_early", 32'(ld_del_head), 32'd0);
      chk("bcast_early", 32'(cmd_buf_ld.reg_id), 32'd0);
      chk("busy_req", 32'(busy), 32'd1);
      if (!exp_ld) begin
        chk("mbe", 32'(dmem_mbe), 32'(ref_mbe(m_stf3, m_staddr)));
        chk("wdata", dmem_wdata, ref_wdata(m_stf3, m_staddr, m_stdata));
      end
    end
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    #1;
    chk("st_pop_resp", 32'(st_del_head), 32'(!exp_ld));
    @(negedge clk);
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    #1;
    chk("st_pop_after", 32'(st_del_head), 32'd0);
    chk("read_done", 32'(dmem_read), 32'd0);
    chk("write_done", 32'(dmem_write), 32'd0);
    if (exp_ld) begin
      chk("ld_pop", 32'(ld_del_head), 32'd1);
      chk("bcast_id", 32'(cmd_buf_ld.reg_id), 32'(m_id));
      chk("bcast_data", cmd_buf_ld.data, ref_load(m_ldf3, m_ldaddr, rdata));
      ld_head_ready = 1'b0;
    end else begin
      chk("st_no_bcast", 32'(cmd_buf_ld.reg_id), 32'd0);
      chk("st_no_ldpop", 32'(ld_del_head), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      st_head_ready = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ld_pop"}, 32'(ld_del_head), 32'd0);
    chk({tag, "_st_pop"}, 32'(st_del_head), 32'd0);
    chk({tag, "_read"}, 32'(dmem_read), 32'd0);
    chk({tag, "_write"}, 32'(dmem_write), 32'd0);
    chk({tag, "_addr"}, dmem_address, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_mbe"}, 32'(dmem_mbe), 32'd0);
    chk({tag, "_bcast_id"}, 32'(cmd_buf_ld.reg_id), 32'd0);
    chk({tag, "_bcast_data"}, cmd_buf_ld.data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b0;
    ld_head_ready = 1'b0;
    st_head_ready = 1'b0;
    dmem_resp     = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst     = 1'b1;
    last_st = 1'b0;
  endtask

  task automatic set_ld(input logic [4:0] id, input logic [2:0] f3, input logic [31:0] a);
    ld_head_ready   = 1'b1;
    ld_head_id      = id;
    ld_head_funct3  = f3;
    ld_head_address = a;
  endtask

  task automatic set_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_head_ready   = 1'b1;
    st_head_funct3  = f3;
    st_head_address = a;
    st_head_data    = d;
  endtask

  initial begin
    bit          got;
    bit          ok_seen;
    int          r;
    logic [2:0]  ld_f3s [5];
    bit          order [4];
    ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    order  = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    ld_head_ready = 1'b0; ld_head_id = '0; ld_head_funct3 = '0; ld_head_address = '0;
    st_head_ready = 1'b0; st_head_funct3 = '0; st_head_address = '0; st_head_data = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    #2 rst = 1'b0;
    do_reset();

    // Single LW with two wait cycles.
    set_ld(5'd7, 3'b010, 32'h0000_1004);
    run_txn(2, 32'hDEAD_BEEF, 1'b0, got);
    chk("lw_bcast_val", cmd_buf_ld.data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lw_pop_one_cycle", 32'(ld_del_head), 32'd0);
    chk("lw_bcast_cleared", 32'(cmd_buf_ld.reg_id), 32'd0);

    // Byte and halfword alignment on the same data word.
    set_ld(5'd3, 3'b000, 32'h0000_2003);
    run_txn(0, 32'h80FF_FFFF, 1'b0, got);
    chk("lb_val", cmd_buf_ld.data, 32'hFFFF_FF80);
    set_ld(5'd4, 3'b100, 32'h0000_2003);
    run_txn(1, 32'h80FF_FFFF, 1'b0, got);
    chk("lbu_val", cmd_buf_ld.data, 32'h0000_0080);
    set_ld(5'd5, 3'b001, 32'h0000_2002);
    run_txn(0, 32'h80FF_FFFF, 1'b0, got);
    chk("lh_val", cmd_buf_ld.data, 32'hFFFF_80FF);
    set_ld(5'd6, 3'b101, 32'h0000_2002);
    run_txn(3, 32'h80FF_FFFF, 1'b0, got);
    chk("lhu_val", cmd_buf_ld.data, 32'h0000_80FF);

    // SB at offset 1.
    @(negedge clk);
    set_st(3'b000, 32'h0000_3001, 32'h0000_00AB);
    @(negedge clk);
    chk("sb_addr", dmem_address, 32'h0000_3000);
    chk("sb_mbe", 32'(dmem_mbe), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h0000_AB00);
    last_st = 1'b1;
    dmem_resp = 1'b1;
    #1;
    chk("sb_pop", 32'(st_del_head), 32'd1);
    chk("sb_no_bcast", 32'(cmd_buf_ld.reg_id), 32'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    st_head_ready = 1'b0;
    #1;
    chk("sb_idle", 32'(busy), 32'd0);

    // Contention from reset: store wins the first tie, then alternation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!ld_head_ready) set_ld(5'($urandom_range(1, 31)), ld_f3s[$urandom_range(0, 4)], $urandom);
      if (!st_head_ready) set_st(3'($urandom_range(0, 2)), $urandom, $urandom);
      run_txn($urandom_range(0, 2), $urandom, 1'b0, got);
      chk("contention_order", 32'(got), 32'(order[i]));
    end
    ld_head_ready = 1'b0;
    st_head_ready = 1'b0;

    // Randomized mix with in-flight head scrambling.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(1, 3);
      ld_head_ready = 1'b0;
      st_head_ready = 1'b0;
      if (r[0]) set_ld(5'($urandom_range(1, 31)), ld_f3s[$urandom_range(0, 4)], $urandom);
      if (r[1]) set_st(3'($urandom_range(0, 2)), $urandom, $urandom);
      run_txn($urandom_range(0, 3), $urandom, 1'b1, got);
    end
    ld_head_ready = 1'b0;
    st_head_ready = 1'b0;

    // Reset in the middle of a load: response afterwards must be dropped.
    @(negedge clk);
    @(negedge clk);
    set_ld(5'd9, 3'b010, 32'h0000_0040);
    ok_seen = 1'b0;
    for (int i = 0; i < 20 && !ok_seen; i++) begin
      @(negedge clk);
      ok_seen = dmem_read;
    end
    chk("midrst_req_seen", 32'(ok_seen), 32'd1);
    rst = 1'b0;
    ld_head_ready = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1234_5678;
    #1;
    chk("midrst_st_pop", 32'(st_del_head), 32'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_reset_outputs("post_rst");
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
